// File: rtl/calc_pkg.sv
// Shared calculator definitions used by the display-path arithmetic blocks.
//   BLANK_DIGIT : nibble that the 7-segment decoder renders as an unlit digit
//   state_t     : two-state encoding of the sequential BCD converter
package calc_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Replicates BLANK_DIGIT across every nibble of an n-digit packed BCD word.
    function automatic logic [31:0] blank_pattern(input int n);
        logic [31:0] pat;
        pat = 32'h0000_0000;
        for (int i = 0; i < n; i++) begin
            pat[4*i +: 4] = BLANK_DIGIT;
        end
        return pat;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One shift-and-add-3 correction cell for a single BCD digit.
//   din  in  4 : work digit before the shift
//   dout out 4 : din + 3 when din >= 5, otherwise din unchanged
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pre-shift correction so that the following doubling carries into the next digit.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
//   clk     in  1          : rising-edge clock
//   reset   in  1          : synchronous, active-low
//   start   in  1          : request, honoured only while idle
//   bin     in  bits       : binary operand captured on an accepted start
//   err_in  in  1          : error flag captured on an accepted start
//   bcd     out 4*digits   : packed BCD result, digit 0 in [3:0]
//   err     out 1          : captured error flag of the last completed request
//   ready   out 1          : one-cycle pulse when bcd/err update
//   busy    out 1          : high while a conversion is in progress
// An error request skips conversion and returns an all-blank digit pattern
// on the very next cycle.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int bits   = 8,
    parameter int digits = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [bits-1:0]       bin,
    input  logic                  err_in,
    output logic [4*digits-1:0]   bcd,
    output logic                  err,
    output logic                  ready,
    output logic                  busy
);

    localparam int CW = $clog2(bits + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(bits - 1);
    localparam int WW = 4 * digits;
    localparam logic [31:0] BLANK_FULL = blank_pattern(digits);
    localparam logic [WW-1:0] BLANK_WORD = BLANK_FULL[WW-1:0];

    state_t          state_r;
    state_t          state_s;
    logic [bits-1:0] shreg_r;
    logic [bits-1:0] shreg_s;
    logic [WW-1:0]   work_r;
    logic [WW-1:0]   work_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic [WW-1:0]   adj_s;
    logic [WW-1:0]   shifted_s;
    logic [WW-1:0]   bcd_s;
    logic            err_s;
    logic            ready_s;
    logic            busy_s;

    genvar g;
    generate
        for (g = 0; g < digits; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (work_r[4*g +: 4]),
                .dout (adj_s[4*g +: 4])
            );
        end
    endgenerate

    // Corrected work register shifted left with the next operand bit entering at the bottom;
    // the top bit falls off, which cannot lose information while 10^digits > 2^bits - 1.
    always_comb begin
        shifted_s = (adj_s << 1) | {{(WW-1){1'b0}}, shreg_r[bits-1]};
    end

    // Next-state and next-output logic for the two-state converter.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        work_s  = work_r;
        cnt_s   = cnt_r;
        bcd_s   = bcd;
        err_s   = err;
        ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (err_in) begin
                        bcd_s   = BLANK_WORD;
                        err_s   = 1'b1;
                        ready_s = 1'b1;
                    end else begin
                        shreg_s = bin;
                        work_s  = {WW{1'b0}};
                        cnt_s   = {CW{1'b0}};
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                work_s  = shifted_s;
                shreg_s = shreg_r << 1;
                cnt_s   = cnt_r + CW'(1);
                if (cnt_r == LAST_CNT) begin
                    bcd_s   = shifted_s;
                    err_s   = 1'b0;
                    ready_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == SHIFT);
    end

    // State, datapath and output registers; reset discards any partial conversion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            shreg_r <= {bits{1'b0}};
            work_r  <= {WW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            bcd     <= {WW{1'b0}};
            err     <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            work_r  <= work_s;
            cnt_r   <= cnt_s;
            bcd     <= bcd_s;
            err     <= err_s;
            ready   <= ready_s;
            busy    <= busy_s;
        end
    end

endmodule
